regfile_scoreboard: RTL
=======================

// Module: regfile_scoreboard
// PURPOSE
//   Parametrised 2-read/1-write register file for the pipelined datapath, with
//   write-to-read bypass and a per-register pending-write scoreboard. The issue
//   stage marks destinations busy and writeback clears them. The hazard unit
//   reads busy1/busy2 to decide stalls. Replaces the fixed 32x32 register file.
// PARAMETERS
//   DATA_W   32  register width in bits
//   ADDR_W   5   register address width; NUM_REGS = 2**ADDR_W
//   ZERO_REG 1   1: register 0 reads 0, and writes and issues to it are ignored
//   BYPASS   1   1: a same-cycle write is forwarded to the read ports
//   PEND_W   2   width of each pending-write counter (max 2**PEND_W-1 outstanding)
//   INIT_R1  1   reset value of register 1
//   INIT_R2  2   reset value of register 2
// PORTS
//   clk          in   1       clock; all state updates on posedge
//   rst          in   1       asynchronous reset, active-high
//   regWrite     in   1       writeback valid: write writeData and retire one pending
//   writeReg     in   ADDR_W  writeback destination
//   writeData    in   DATA_W  writeback data
//   readReg1     in   ADDR_W  read port 1 address
//   readReg2     in   ADDR_W  read port 2 address
//   readData1    out  DATA_W  read port 1 data (combinational)
//   readData2    out  DATA_W  read port 2 data (combinational)
//   busy1        out  1       readReg1 has an outstanding write
//   busy2        out  1       readReg2 has an outstanding write
//   issueValid   in   1       issue stage claims issueReg as a destination
//   issueReg     in   ADDR_W  destination being claimed
//   issueReady   out  1       issueReg counter can accept one more claim
//   flush        in   1       pipeline flush: clear all pending counters
//   sbErr        out  1       sticky: underflow or overflow attempt seen
// BEHAVIOUR
//   Reset (async, rst=1): all registers 0, except reg1=INIT_R1 and reg2=INIT_R2.
//     All counters 0 and sbErr=0. Outputs follow: busy*=0, issueReady=1.
//   Write: at posedge, if regWrite, then reg[writeReg] <= writeData.
//     If ZERO_REG and writeReg==0, the write is dropped.
//   Read: readDataN = reg[readRegN], with no latency.
//     If ZERO_REG and readRegN==0, readDataN = 0 regardless of other inputs.
//     If BYPASS, regWrite=1, writeReg==readRegN and the write is not dropped:
//       readDataN = writeData.
//   Counters cnt[r], one per register, each PEND_W bits:
//     issue only (valid, not ignored)  -> cnt+1
//     writeback only                   -> cnt-1
//     both on the same reg, same cycle -> cnt unchanged
//     flush=1 -> all cnt <= 0. Flush overrides issue and writeback on counters.
//       The register-array write still occurs during flush.
//   An issue is ignored when:
//     issueReg==0 with ZERO_REG; or
//     issueReady=0 (this also sets sbErr).
//   Writeback with cnt==0 and no same-cycle issue to that reg:
//     cnt stays 0 and sbErr <= 1. Not flagged if flush=1 or the reg is a dropped reg 0.
//   issueReady = (cnt[issueReg] != max) || (regWrite && writeReg==issueReg).
//   busyN = cnt[readRegN] != 0, with two exceptions:
//     forced to 0 for reg 0 when ZERO_REG;
//     with BYPASS, forced to 0 when cnt==1 and writeback to readRegN is this cycle.
//   sbErr clears only on rst.
//   rst asserted mid-operation: same as reset. In-flight issue/writeback are lost.
// TESTING
//   1. Reset -> read r1=1, r2=2, r5=0; busy1=busy2=0; issueReady=1; sbErr=0.
//   2. Write r3=0xDEADBEEF with readReg1=3 in the same cycle.
//      Same cycle: readData1=0xDEADBEEF (BYPASS=1). Next cycle: still 0xDEADBEEF.
//   3. Write r0=0x55 and issue r0 -> readData(r0)=0, busy=0, sbErr=0.
//   4. Issue r7 three times -> issueReady=0. A 4th issue: ignored, sbErr=1.
//      Then 3 writebacks to r7 -> busy1 (readReg1=7) falls in the 3rd writeback cycle.
//   5. Issue and writeback r9 in the same cycle with cnt=1 -> cnt stays 1, busy stays 1.
//      Then flush -> busy=0. Then writeback r9: register written, sbErr=1.
//   6. Assert rst asynchronously mid-cycle with counters nonzero -> all busy=0 immediately.
//      Registers return to init values without waiting for a clock edge.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
//   Two-read / one-write register file for the pipelined datapath, with
//   write-to-read forwarding and a per-register pending-write scoreboard.
//   The issue stage claims destinations (counter +1), writeback retires them
//   (counter -1). The hazard unit stalls on busy1/busy2.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   regWrite/writeReg/writeData   writeback: write data, retire one pending
//   readReg1/2 -> readData1/2     combinational read ports
//   busy1/busy2              read address has an outstanding write
//   issueValid/issueReg      issue stage claims a destination register
//   issueReady               claimed register's counter has room
//   flush                    clear every pending counter
//   sbErr                    sticky underflow/overflow flag
// -----------------------------------------------------------------------------
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int PEND_W   = 2,
    parameter int INIT_R1  = 1,
    parameter int INIT_R2  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              regWrite,
    input  logic [ADDR_W-1:0] writeReg,
    input  logic [DATA_W-1:0] writeData,
    input  logic [ADDR_W-1:0] readReg1,
    input  logic [ADDR_W-1:0] readReg2,
    output logic [DATA_W-1:0] readData1,
    output logic [DATA_W-1:0] readData2,
    output logic              busy1,
    output logic              busy2,
    input  logic              issueValid,
    input  logic [ADDR_W-1:0] issueReg,
    output logic              issueReady,
    input  logic              flush,
    output logic              sbErr
);

    localparam int                NUM_REGS = 2 ** ADDR_W;
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [PEND_W-1:0] cnt_q  [NUM_REGS];
    logic [PEND_W-1:0] cnt_d  [NUM_REGS];
    logic              sb_err_q;
    logic              sb_err_d;

    logic wr_drop;     // write to hard-wired zero register
    logic wr_en;       // write that actually lands in the array
    logic issue_zero;  // issue to hard-wired zero register
    logic issue_ok;    // accepted claim
    logic overflow;    // claim refused because the counter is full

    assign wr_drop    = (ZERO_REG != 0) && (writeReg == '0);
    assign wr_en      = regWrite && !wr_drop;
    assign issue_zero = (ZERO_REG != 0) && (issueReg == '0);

    // A full counter can still take a claim if the same register retires
    // one this cycle: the two cancel and the count stays at max.
    assign issueReady = (cnt_q[issueReg] != PEND_MAX) ||
                        (regWrite && (writeReg == issueReg));
    assign issue_ok   = issueValid && !issue_zero && issueReady;
    assign overflow   = issueValid && !issue_zero && !issueReady;

    // Read-port data: zero register beats forwarding, forwarding beats array.
    function automatic logic [DATA_W-1:0] port_data(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              fwd_en,
        input logic [ADDR_W-1:0] fwd_addr,
        input logic [DATA_W-1:0] fwd_data
    );
        if ((ZERO_REG != 0) && (addr == '0))
            return '0;
        if ((BYPASS != 0) && fwd_en && (fwd_addr == addr))
            return fwd_data;
        return stored;
    endfunction

    // Busy: the last outstanding write retiring this cycle is already
    // visible through the forwarding path, so no stall is needed.
    function automatic logic port_busy(
        input logic [ADDR_W-1:0] addr,
        input logic [PEND_W-1:0] cnt,
        input logic              wb_en,
        input logic [ADDR_W-1:0] wb_addr
    );
        if ((ZERO_REG != 0) && (addr == '0))
            return 1'b0;
        if ((BYPASS != 0) && wb_en && (wb_addr == addr) && (cnt == PEND_ONE))
            return 1'b0;
        return cnt != '0;
    endfunction

    always_comb begin
        readData1 = port_data(readReg1, regs_q[readReg1], wr_en, writeReg, writeData);
        readData2 = port_data(readReg2, regs_q[readReg2], wr_en, writeReg, writeData);
        busy1     = port_busy(readReg1, cnt_q[readReg1], regWrite, writeReg);
        busy2     = port_busy(readReg2, cnt_q[readReg2], regWrite, writeReg);
    end

    assign sbErr = sb_err_q;

    // Counter next state. Flush wins over claims and retirements; a
    // retirement against an empty counter (with no same-cycle claim to
    // cancel it) is an underflow.
    // NOTE: every always_comb output gets its default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        sb_err_d = sb_err_q | overflow;
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (flush) begin
                cnt_d[i] = '0;
            end else if (issue_ok && (issueReg == ADDR_W'(i)) &&
                         !(wr_en && (writeReg == ADDR_W'(i)))) begin
                cnt_d[i] = cnt_q[i] + PEND_ONE;
            end else if (wr_en && (writeReg == ADDR_W'(i)) &&
                         !(issue_ok && (issueReg == ADDR_W'(i)))) begin
                if (cnt_q[i] == '0)
                    sb_err_d = 1'b1;
                else
                    cnt_d[i] = cnt_q[i] - PEND_ONE;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    // NOTE: the register array is reset on purpose: architectural state must
    // come up with known values (r1/r2 preloaded), not just the control bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= (i == 1) ? DATA_W'(INIT_R1) :
                             (i == 2) ? DATA_W'(INIT_R2) : '0;
                cnt_q[i]  <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            if (wr_en)
                regs_q[writeReg] <= writeData;
            for (int i = 0; i < NUM_REGS; i++)
                cnt_q[i] <= cnt_d[i];
            sb_err_q <= sb_err_d;
        end
    end

endmodule
